if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the MIPS32 pipeline. Owns the fetch PC and issues single-outstanding word fetches to instruction memory over a req/gnt/rvalid handshake. Delivers pc, pc+4, instruction and a valid flag to the IF/ID pipeline register. Honours hazard stalls and branch/jump redirects from decode, and holds returned data in a one-entry skid buffer while downstream is stalled.

## Interface
- RESET_PC, 32'h0000_3000, first fetch address after reset
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall_i  in  1  downstream stall; output registers hold
- redirect_i  in  1  branch/jump taken; flush IF and refetch
- redirect_pc_i  in  32  redirect target
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch word address
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  read data valid, at least 1 cycle after gnt
- imem_rdata_i  in  32  instruction word
- if_pc  out  32  pc of delivered instruction
- if_pc_plus_4  out  32  if_pc + 4
- if_inst  out  32  delivered instruction
- if_valid  out  1  if_pc/if_inst hold a real instruction
- if_exc_adel  out  1  misaligned fetch address exception (see Configuration)

## Operation
- Registers: next_pc (address of the next request), req_pc (address in flight), kill flag, skid {valid, pc, inst}, output registers.
- Instruction is consumed by downstream on every rising edge where if_valid=1 and stall_i=0. The output register is free when if_valid=0 or stall_i=0.
- FSM:
  - IDLE: first cycle after reset release; go to REQ.
  - REQ: drive imem_req_o=1 and imem_addr_o=next_pc. On imem_gnt_i: req_pc<=next_pc, next_pc<=next_pc+4, go to WAIT.
  - WAIT: imem_req_o=0. On imem_rvalid_i:
    - if kill is set: drop the data, clear kill, go to REQ.
    - else if the output register is free: load {req_pc, req_pc+4, rdata}, set if_valid=1, go to REQ.
    - else: load the skid buffer, go to HOLD.
  - HOLD: no request. When stall_i=0: move skid to the output register, clear skid, go to REQ.
- If the output register is free and no new data is loaded, if_valid<=0.
- Redirect (priority over stall_i and all other events):
  - next_pc<=redirect_pc_i; if_valid<=0; skid cleared.
  - In WAIT with no rvalid that cycle: set kill and stay in WAIT.
  - In WAIT with rvalid that cycle: discard the data and go to REQ.
  - In REQ with gnt that cycle: the granted request is killed; go to WAIT with kill=1.
  - In REQ without gnt: the request is withdrawn and reissued at redirect_pc_i the next cycle.
  - In HOLD or IDLE: go to REQ.
- Delay slots are the responsibility of decode/control. Control asserts redirect_i only after the delay-slot instruction has been consumed.
- Arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
- imem_addr_o[1:0] is always 0.

## Timing
- Reset values:
  - if_pc=RESET_PC, if_pc_plus_4=RESET_PC+4, if_inst=0, if_valid=0, if_exc_adel=0
  - imem_req_o=0, imem_addr_o=RESET_PC, next_pc=RESET_PC
  - kill=0, skid empty, state IDLE
- First imem_req_o is asserted on the second edge after reset release.
- With zero-wait memory (gnt in the req cycle, rvalid 1 cycle later): if_valid rises 2 cycles after gnt. Throughput is one instruction per 2 cycles.
- If reset asserts mid-transaction, all state returns to reset values immediately. A late rvalid after reset is ignored because the FSM is in IDLE.
- imem_addr_o is stable while imem_req_o=1 and imem_gnt_i=0, except on a redirect.

## Configuration
- IF_ALIGN_CHECK_EN defined:
  - A redirect to an address with [1:0]!=0 issues no fetch.
  - Next cycle: if_valid=1, if_inst=0 (NOP), if_pc=redirect_pc_i, if_exc_adel=1.
  - This output is held under stall. After it is consumed, the FSM waits in IDLE until the next redirect.
- IF_ALIGN_CHECK_EN undefined: redirect_pc_i[1:0] is forced to 0 and if_exc_adel is tied to 0.

## Test plan
- Reset release, zero-wait memory returning rdata=addr^32'hA5A5_0000 -> fetches at 0x3000, 0x3004, 0x3008. if_pc and if_pc_plus_4 match each address, and if_valid pulses every 2 cycles.
- stall_i high for 5 cycles while if_valid=1 and the next rvalid arrives -> outputs unchanged, skid loaded, no req. On release, the skid instruction appears the next cycle with pc+4.
- redirect_i to 0x0040_0000 while in WAIT, with rvalid 3 cycles later -> returned data discarded, next req at 0x0040_0000, and the first if_pc after the redirect is 0x0040_0000.
- redirect_i and imem_rvalid_i in the same cycle, with stall_i=1 -> data dropped, if_valid=0 next cycle, req at the target.
- Redirect to 0xFFFF_FFFC -> fetch at 0xFFFF_FFFC with if_pc_plus_4=0, then the next fetch is at 0x0000_0000.
- With IF_ALIGN_CHECK_EN defined, redirect to 0x0000_3002 -> no req; if_valid=1, if_inst=0, if_exc_adel=1, if_pc=0x3002. Without the macro, the fetch goes to 0x3000.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC and issues one outstanding word
// fetch at a time over req/gnt/rvalid. A one-entry skid buffer absorbs a
// response that arrives while downstream is stalled.
// Optional feature macro: IF_ALIGN_CHECK_EN (misaligned redirect -> AdEL NOP).
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus_4,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        if_exc_adel
);

  localparam int unsigned XLEN = 32;

`ifdef IF_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_ADEL} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   next_pc_q, next_pc_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic              kill_q, kill_d;
  logic              halt_q, halt_d;
  logic              skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
  logic [XLEN-1:0]   skid_inst_q, skid_inst_d;
  logic              req_q, req_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pc4_q, pc4_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              adel_q, adel_d;

  logic              out_free_c;
  logic              misalign_c;
  logic [XLEN-1:0]   redir_tgt_c;

  assign out_free_c  = !valid_q || !stall_i;
  assign misalign_c  = ALIGN_CHECK && (redirect_pc_i[1:0] != 2'b00);
  assign redir_tgt_c = {redirect_pc_i[XLEN-1:2], 2'b00};

  assign imem_req_o   = req_q;
  assign imem_addr_o  = next_pc_q;
  assign if_pc        = pc_q;
  assign if_pc_plus_4 = pc4_q;
  assign if_inst      = inst_q;
  assign if_valid     = valid_q;
  assign if_exc_adel  = adel_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a redirect overrides every other event
  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      if (misalign_c) begin
        state_d = S_ADEL;
      end else begin
        case (state_q)
          S_REQ:   state_d = imem_gnt_i ? S_WAIT : S_REQ;
          S_WAIT:  state_d = imem_rvalid_i ? S_REQ : S_WAIT;
          default: state_d = S_REQ;
        endcase
      end
    end else begin
      case (state_q)
        S_IDLE: if (!halt_q) state_d = S_REQ;
        S_REQ:  if (imem_gnt_i) state_d = S_WAIT;
        S_WAIT: if (imem_rvalid_i) state_d = (kill_q || out_free_c) ? S_REQ : S_HOLD;
        S_HOLD: if (!stall_i) state_d = S_REQ;
        S_ADEL: if (!stall_i) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and output next-values
  always_comb begin
    next_pc_d    = next_pc_q;
    req_pc_d     = req_pc_q;
    kill_d       = kill_q;
    halt_d       = halt_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    pc_d         = pc_q;
    pc4_d        = pc4_q;
    inst_d       = inst_q;
    valid_d      = valid_q;
    adel_d       = adel_q;
    req_d        = (state_d == S_REQ);

    // A consumed (or empty) output slot drops its valid unless refilled below
    if (out_free_c) begin
      valid_d = 1'b0;
      adel_d  = 1'b0;
    end
    // Outside WAIT any rvalid can only be a stale, already-killed response
    if (imem_rvalid_i && (state_q != S_WAIT)) kill_d = 1'b0;

    if (redirect_i) begin
      next_pc_d    = redir_tgt_c;
      valid_d      = 1'b0;
      adel_d       = 1'b0;
      skid_valid_d = 1'b0;
      halt_d       = 1'b0;
      if ((state_q == S_REQ && imem_gnt_i) || (state_q == S_WAIT && !imem_rvalid_i))
        kill_d = 1'b1;
      else if (state_q == S_WAIT)
        kill_d = 1'b0;
      if (misalign_c) begin
        valid_d = 1'b1;
        adel_d  = 1'b1;
        pc_d    = redirect_pc_i;
        pc4_d   = redirect_pc_i + XLEN'(4);
        inst_d  = '0;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_gnt_i) begin
            req_pc_d  = next_pc_q;
            next_pc_d = next_pc_q + XLEN'(4);
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            if (kill_q) begin
              kill_d = 1'b0;
            end else if (out_free_c) begin
              pc_d    = req_pc_q;
              pc4_d   = req_pc_q + XLEN'(4);
              inst_d  = imem_rdata_i;
              valid_d = 1'b1;
            end else begin
              skid_valid_d = 1'b1;
              skid_pc_d    = req_pc_q;
              skid_inst_d  = imem_rdata_i;
            end
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            pc_d         = skid_pc_q;
            pc4_d        = skid_pc_q + XLEN'(4);
            inst_d       = skid_inst_q;
            valid_d      = 1'b1;
            skid_valid_d = 1'b0;
          end
        end
        S_ADEL: begin
          if (!stall_i) halt_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_pc_q    <= RESET_PC;
      req_pc_q     <= RESET_PC;
      kill_q       <= 1'b0;
      halt_q       <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= '0;
      req_q        <= 1'b0;
      pc_q         <= RESET_PC;
      pc4_q        <= RESET_PC + XLEN'(4);
      inst_q       <= '0;
      valid_q      <= 1'b0;
      adel_q       <= 1'b0;
    end else begin
      next_pc_q    <= next_pc_d;
      req_pc_q     <= req_pc_d;
      kill_q       <= kill_d;
      halt_q       <= halt_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      req_q        <= req_d;
      pc_q         <= pc_d;
      pc4_q        <= pc4_d;
      inst_q       <= inst_d;
      valid_q      <= valid_d;
      adel_q       <= adel_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a bench-side memory responder plus a scoreboard
// of expected delivered instructions, checked as downstream consumes them.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus_4;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        if_exc_adel;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          n_consumed = 0;
  int          cons_cyc[$];
  int          n_before;
  logic [31:0] exp_fetch;
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          lat = 1;
  logic        gnt_en = 1'b1;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_pc         (if_pc),
    .if_pc_plus_4  (if_pc_plus_4),
    .if_inst       (if_inst),
    .if_valid      (if_valid),
    .if_exc_adel   (if_exc_adel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle, evaluated at the falling edge: memory drive, consume check
  task automatic cycle();
    exp_t e;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_addr ^ KEY;
        mem_pend      = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    imem_gnt_i = rst_n && imem_req_o && gnt_en && !mem_pend;
    if (imem_gnt_i) begin
      chk("fetch_addr", imem_addr_o, exp_fetch);
      if (!redirect_i) sb.push_back('{exp_fetch, exp_fetch ^ KEY, 1'b0});
      mem_pend  = 1'b1;
      mem_addr  = imem_addr_o;
      mem_cnt   = lat - 1;
      exp_fetch = exp_fetch + 32'd4;
    end
    if (rst_n && if_valid && !stall_i) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_empty: observed=valid pc %h expected=no instruction", if_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("cons_pc", if_pc, e.pc);
        chk("cons_pc4", if_pc_plus_4, e.pc + 32'd4);
        chk("cons_inst", if_inst, e.inst);
        chk("cons_exc", 32'(if_exc_adel), 32'(e.exc));
      end
      n_consumed++;
      cons_cyc.push_back(cyc);
    end
    if (redirect_i) begin
      sb.delete();
`ifdef IF_ALIGN_CHECK_EN
      if (redirect_pc_i[1:0] != 2'b00) sb.push_back('{redirect_pc_i, 32'h0, 1'b1});
      else exp_fetch = redirect_pc_i;
`else
      exp_fetch = {redirect_pc_i[31:2], 2'b00};
`endif
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    exp_fetch = RESET_PC; mem_pend = 1'b0; mem_addr = '0; mem_cnt = 0;
    @(negedge clk); @(negedge clk);

    // Reset values
    chk("rst_pc", if_pc, RESET_PC);
    chk("rst_pc4", if_pc_plus_4, RESET_PC + 32'd4);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_exc", 32'(if_exc_adel), 32'd0);
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_addr", imem_addr_o, RESET_PC);

    // Zero-wait fetch stream from RESET_PC
    rst_n = 1'b1;
    chk("idle_req", 32'(imem_req_o), 32'd0);
    repeat (4) cycle();
    chk("valid_gap", 32'(if_valid), 32'd0);
    repeat (4) cycle();
    chk("stream_cnt", 32'(n_consumed), 32'd3);
    chk("first_lat", 32'(cons_cyc[0]), 32'd3);
    chk("period_a", 32'(cons_cyc[1] - cons_cyc[0]), 32'd2);
    chk("period_b", 32'(cons_cyc[2] - cons_cyc[1]), 32'd2);

    // Stall with a response landing in the skid buffer
    cycle();
    chk("pre_stall_valid", 32'(if_valid), 32'd1);
    chk("pre_stall_pc", if_pc, 32'h0000_300C);
    stall_i = 1'b1;
    cycle();
    cycle();
    for (int k = 0; k < 3; k++) begin
      chk("hold_req", 32'(imem_req_o), 32'd0);
      chk("hold_pc", if_pc, 32'h0000_300C);
      chk("hold_inst", if_inst, 32'h0000_300C ^ KEY);
      cycle();
    end
    stall_i = 1'b0;
    cycle();
    chk("skid_pc", if_pc, 32'h0000_3010);
    chk("skid_pc4", if_pc_plus_4, 32'h0000_3014);
    cycle();
    cycle();

    // Redirect while waiting, stale response three cycles after grant
    lat = 3;
    cycle();
    chk("stream_cnt2", 32'(n_consumed), 32'd6);
    chk("in_wait_req", 32'(imem_req_o), 32'd0);
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0000;
    cycle();
    redirect_i = 1'b0; lat = 1;
    cycle();
    chk("kill_valid", 32'(if_valid), 32'd0);
    cycle();
    chk("refetch_req", 32'(imem_req_o), 32'd1);
    cycle();
    cycle();
    chk("redir_pc", if_pc, 32'h0040_0000);

    // Redirect coinciding with rvalid under stall, target at top of memory
    stall_i = 1'b1;
    cycle();
    chk("stalled_valid", 32'(if_valid), 32'd1);
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    cycle();
    redirect_i = 1'b0; stall_i = 1'b0;
    chk("drop_valid", 32'(if_valid), 32'd0);
    chk("top_req", 32'(imem_req_o), 32'd1);
    chk("top_addr", imem_addr_o, 32'hFFFF_FFFC);
    cycle();
    cycle();
    chk("wrap_pc4", if_pc_plus_4, 32'h0000_0000);
    cycle();
    cycle();
    gnt_en = 1'b0;
    cycle();

    // Misaligned redirect while a request is pending without grant
    chk("pre_mis_req", 32'(imem_req_o), 32'd1);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_3002;
    cycle();
    redirect_i = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
    chk("adel_req", 32'(imem_req_o), 32'd0);
    chk("adel_valid", 32'(if_valid), 32'd1);
    chk("adel_pc", if_pc, 32'h0000_3002);
    chk("adel_inst", if_inst, 32'h0);
    chk("adel_exc", 32'(if_exc_adel), 32'd1);
    stall_i = 1'b1;
    cycle();
    chk("adel_hold_exc", 32'(if_exc_adel), 32'd1);
    chk("adel_hold_valid", 32'(if_valid), 32'd1);
    stall_i = 1'b0;
    cycle();
    chk("adel_done_valid", 32'(if_valid), 32'd0);
    chk("adel_done_exc", 32'(if_exc_adel), 32'd0);
    gnt_en = 1'b1;
    repeat (3) cycle();
    chk("halt_req", 32'(imem_req_o), 32'd0);
    lat = 3;
    redirect_i = 1'b1; redirect_pc_i = RESET_PC;
    cycle();
    redirect_i = 1'b0;
`else
    chk("mask_req", 32'(imem_req_o), 32'd1);
    chk("mask_addr", imem_addr_o, 32'h0000_3000);
    gnt_en = 1'b1;
    cycle();
    cycle();
    chk("mask_exc", 32'(if_exc_adel), 32'd0);
    lat = 3;
`endif

    // Reset in the middle of a transaction; late response must be ignored
    for (int i = 0; i < 10 && !mem_pend; i++) cycle();
    chk("grant_seen", 32'(mem_pend), 32'd1);
    cycle();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(if_valid), 32'd0);
    chk("mid_rst_req", 32'(imem_req_o), 32'd0);
    chk("mid_rst_addr", imem_addr_o, RESET_PC);
    chk("mid_rst_pc", if_pc, RESET_PC);
    sb.delete();
    exp_fetch = RESET_PC;
    lat = 1;
    cycle();
    rst_n = 1'b1;
    n_before = n_consumed;
    repeat (6) cycle();
    chk("post_rst_cnt", 32'(n_consumed - n_before), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
